// File: rtl/extrinsic_reorder.sv
// extrinsic_reorder: buffers one block of extrinsic LLRs that arrive in
// reverse order (bit K-1 first) and replays them in natural order.
// Ports:
//   clk, rst            clock, async active-high reset
//   blklen/valid_blklen block length K and its start-of-block strobe
//   extrinsic/valid_*   reverse-order LLR input, no backpressure
//   out_ready           downstream accepts the current output word
//   extrinsic_out       natural-order LLR, with hard_bit (sign) and last_out
//   valid_out           output word valid
//   busy                high while a block is being filled or drained
//   err_len/err_overrun one-cycle error pulses
module extrinsic_reorder #(
   parameter int DATA_W     = 16,
   parameter int MAX_BLKLEN = 6144,
   parameter int MIN_BLKLEN = 40,
   parameter int ADDR_W     = 13
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       blklen,
   input  logic              valid_blklen,
   input  logic [DATA_W-1:0] extrinsic,
   input  logic              valid_extrinsic,
   input  logic              out_ready,
   output logic [DATA_W-1:0] extrinsic_out,
   output logic              hard_bit,
   output logic              valid_out,
   output logic              last_out,
   output logic              busy,
   output logic              err_len,
   output logic              err_overrun
);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   localparam logic [15:0]     MIN_L = 16'(MIN_BLKLEN);
   localparam logic [15:0]     MAX_L = 16'(MAX_BLKLEN);
   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

   state_t            state;
   logic [DATA_W-1:0] mem [MAX_BLKLEN];
   logic [ADDR_W:0]   blk_len;
   logic [ADDR_W:0]   wr_cnt;
   logic [ADDR_W:0]   rd_cnt;
   logic [ADDR_W:0]   wr_idx;
   logic [DATA_W-1:0] rd_q;
   logic              rd_vld;
   logic              rd_last;
   logic              len_ok;
   logic              wr_en;
   logic              rd_en;
   logic              advance;

   assign len_ok  = (blklen >= MIN_L) && (blklen <= MAX_L);
   assign wr_en   = (state == FILL) && valid_extrinsic;
   assign wr_idx  = blk_len - wr_cnt - ONE;
   // The RAM read register and the output register form a two-stage
   // pipeline that stalls as a whole: both stages move only when the
   // output register is free or being accepted in this cycle.
   assign advance = !valid_out || out_ready;
   assign rd_en   = (state == DRAIN) && advance && (rd_cnt < blk_len);
   assign busy     = (state != IDLE);
   assign hard_bit = extrinsic_out[DATA_W-1];

   // Buffer RAM; contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx[ADDR_W-1:0]] <= extrinsic;
      if (rd_en) rd_q <= mem[rd_cnt[ADDR_W-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         blk_len       <= '0;
         wr_cnt        <= '0;
         rd_cnt        <= '0;
         rd_vld        <= 1'b0;
         rd_last       <= 1'b0;
         extrinsic_out <= '0;
         valid_out     <= 1'b0;
         last_out      <= 1'b0;
         err_len       <= 1'b0;
         err_overrun   <= 1'b0;
      end else begin
         err_len     <= 1'b0;
         err_overrun <= valid_extrinsic && (state != FILL);

         if (advance) begin
            rd_vld    <= rd_en;
            rd_last   <= rd_en && (rd_cnt == blk_len - ONE);
            valid_out <= rd_vld;
            last_out  <= rd_vld && rd_last;
            if (rd_vld) extrinsic_out <= rd_q;
         end
         if (rd_en) rd_cnt <= rd_cnt + ONE;

         unique case (state)
            IDLE: begin
               if (valid_blklen) begin
                  if (len_ok) begin
                     blk_len <= blklen[ADDR_W:0];
                     wr_cnt  <= '0;
                     state   <= FILL;
                  end else begin
                     err_len <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (valid_extrinsic) begin
                  wr_cnt <= wr_cnt + ONE;
                  if (wr_cnt == blk_len - ONE) begin
                     rd_cnt <= '0;
                     state  <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (valid_out && out_ready && last_out) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_extrinsic_reorder.sv
// tb_extrinsic_reorder: directed scoreboard bench for extrinsic_reorder.
// Stimulus pushes natural-order expectations; a negedge monitor checks them.
module tb_extrinsic_reorder;

   logic        clk = 0;
   logic        rst = 1;
   logic [15:0] blklen = 0;
   logic        valid_blklen = 0;
   logic [15:0] extrinsic = 0;
   logic        valid_extrinsic = 0;
   logic        out_ready = 1;
   logic [15:0] extrinsic_out;
   logic        hard_bit, valid_out, last_out, busy, err_len, err_overrun;

   int checks = 0;
   int failures = 0;
   bit rand_ready = 0;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   extrinsic_reorder dut (
      .clk(clk), .rst(rst), .blklen(blklen), .valid_blklen(valid_blklen),
      .extrinsic(extrinsic), .valid_extrinsic(valid_extrinsic),
      .out_ready(out_ready), .extrinsic_out(extrinsic_out),
      .hard_bit(hard_bit), .valid_out(valid_out), .last_out(last_out),
      .busy(busy), .err_len(err_len), .err_overrun(err_overrun)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Natural-order value of word i for each stimulus pattern.
   function automatic logic [15:0] pat(input int mode, input int i);
      case (mode)
         0: return 16'(i);
         1: return (i % 3 == 0) ? 16'h8000 : (i % 3 == 1) ? 16'h7fff : 16'h0000;
         2: return 16'(i * 1000 - 24000);
         default: return 16'(i * 37 + 12345);
      endcase
   endfunction

   // Drives out_ready just after each rising edge.
   initial forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Scoreboard monitor.
   bit          stall_prev = 0;
   bit          idle_next = 0;
   logic [15:0] hold_d;
   logic        hold_l;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         stall_prev = 0;
         idle_next  = 0;
      end else begin
         if (idle_next) begin
            chk("busy_fall", 32'(busy), 32'd0);
            idle_next = 0;
         end
         if (valid_out) begin
            if (stall_prev)
               chk("stall_hold", 32'({extrinsic_out, last_out}),
                   32'({hold_d, hold_l}));
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out", 32'(valid_out), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_word", 32'({extrinsic_out, hard_bit, last_out}),
                      32'({e.data, e.data[15], e.last}));
                  if (e.last) begin
                     chk("busy_at_last", 32'(busy), 32'd1);
                     idle_next = 1;
                  end
               end
            end
         end
         stall_prev = valid_out && !out_ready;
         hold_d     = extrinsic_out;
         hold_l     = last_out;
      end
   end

   // Starts a block of length k and sends its first nsend words.
   task automatic send_block(input int k, input int mode, input bit gap,
                             input int nsend, input bit push);
      if (push)
         for (int i = 0; i < k; i++)
            exp_q.push_back('{data: pat(mode, i), last: (i == k - 1)});
      blklen       = 16'(k);
      valid_blklen = 1;
      @(posedge clk);
      #1 valid_blklen = 0;
      @(negedge clk);
      chk("busy_rise", 32'(busy), 32'd1);
      for (int j = 0; j < nsend; j++) begin
         while (gap && $urandom_range(0, 1) == 0) begin
            valid_extrinsic = 0;
            @(posedge clk);
            #1;
         end
         valid_extrinsic = 1;
         extrinsic       = pat(mode, k - 1 - j);
         @(posedge clk);
         #1 valid_extrinsic = 0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(n < 20000), 32'd1);
      @(negedge clk);
   endtask

   task automatic bad_len(input logic [15:0] len);
      blklen       = len;
      valid_blklen = 1;
      @(posedge clk);
      #1 valid_blklen = 0;
      @(negedge clk);
      chk("err_len_pulse", 32'({err_len, busy}), 32'b10);
      @(negedge clk);
      chk("err_len_clear", 32'({err_len, busy}), 32'b00);
   endtask

   task automatic check_reset_outputs(input string name);
      chk(name, 32'({extrinsic_out, hard_bit, valid_out, last_out, busy,
                     err_len, err_overrun}), 32'd0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset_state");
      rst = 0;
      @(negedge clk);

      // Basic reorder with latency check.
      send_block(40, 0, 0, 40, 1);
      @(negedge clk);
      chk("lat_n0", 32'(valid_out), 32'd0);
      @(negedge clk);
      chk("lat_n1", 32'(valid_out), 32'd0);
      @(negedge clk);
      chk("lat_n2", 32'({valid_out, extrinsic_out}), 32'({1'b1, 16'd0}));
      wait_idle();

      // Sign / hard decision pattern.
      send_block(40, 1, 0, 40, 1);
      wait_idle();

      // Random backpressure.
      rand_ready = 1;
      send_block(48, 2, 0, 48, 1);
      wait_idle();
      rand_ready = 0;

      // Length errors, then a good length.
      bad_len(16'd0);
      bad_len(16'd39);
      bad_len(16'd6145);
      send_block(40, 3, 0, 40, 1);
      wait_idle();

      // Overrun during drain.
      send_block(40, 0, 0, 40, 1);
      @(negedge clk);
      @(posedge clk);
      #1 valid_extrinsic = 1;
      extrinsic = 16'hdead;
      @(posedge clk);
      #1 valid_extrinsic = 0;
      @(negedge clk);
      chk("overrun_pulse", 32'(err_overrun), 32'd1);
      @(negedge clk);
      chk("overrun_clear", 32'(err_overrun), 32'd0);
      wait_idle();

      // Reset mid-fill.
      send_block(40, 2, 0, 20, 0);
      rst = 1;
      #1 check_reset_outputs("reset_mid_fill");
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // Reset mid-drain.
      send_block(40, 3, 0, 40, 1);
      n = 0;
      while (!valid_out && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("drain_start", 32'(valid_out), 32'd1);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 rst = 1;
      exp_q.delete();
      #1 check_reset_outputs("reset_mid_drain");
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // Fresh block after reset.
      send_block(40, 0, 0, 40, 1);
      wait_idle();

      // Maximum length, gapped input.
      send_block(6144, 3, 1, 6144, 1);
      wait_idle();

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
